// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin share of one combinational ALU between two requesters
module alu_share_arbiter #(
  parameter int DATA_W = 64,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [2*DATA_W-1:0] req_imm,
  input  logic [2*OP_W-1:0]   req_op,
  input  logic [1:0]          req_alusrc,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [DATA_W-1:0]   alu_imm,
  output logic [OP_W-1:0]     alu_op,
  output logic                alu_alusrc,
  input  logic [DATA_W-1:0]   alu_result,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_result,
  output logic                rsp_zero,
  output logic                busy,
  output logic [CNT_W-1:0]    op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  state_t state_next;

  logic last_grant;  // index of the requester served most recently
  logic grant_idx;   // index of the requester owning the op in flight
  logic win;         // arbitration winner in the current IDLE cycle
  logic any_req;
  logic rsp_fire;

  // Arbitration: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    any_req = |req_valid;
    win     = 1'b0;
    case (req_valid)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_grant;
      default: win = 1'b0;
    endcase
  end

  // Only the owner's rsp_ready completes the response; the other bit is ignored.
  assign rsp_fire = rsp_ready[grant_idx];
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the combinational accept strobe.
  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    case (state)
      IDLE: begin
        if (any_req) begin
          req_ready  = win ? 2'b10 : 2'b01;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_fire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch winner's operands, capture the ALU result, hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      grant_idx  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_imm    <= '0;
      alu_op     <= '0;
      alu_alusrc <= 1'b0;
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_idx  <= win;
            alu_a      <= win ? req_a[2*DATA_W-1:DATA_W]   : req_a[DATA_W-1:0];
            alu_b      <= win ? req_b[2*DATA_W-1:DATA_W]   : req_b[DATA_W-1:0];
            alu_imm    <= win ? req_imm[2*DATA_W-1:DATA_W] : req_imm[DATA_W-1:0];
            alu_op     <= win ? req_op[2*OP_W-1:OP_W]      : req_op[OP_W-1:0];
            alu_alusrc <= win ? req_alusrc[1]              : req_alusrc[0];
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= (alu_result == '0);
          rsp_valid  <= grant_idx ? 2'b10 : 2'b01;
        end
        RESP: begin
          if (rsp_fire) begin
            rsp_valid  <= 2'b00;
            last_grant <= grant_idx;
            op_count   <= op_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter
module tb_alu_share_arbiter;

  localparam int DATA_W = 64;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*DATA_W-1:0] req_a, req_b, req_imm;
  logic [2*OP_W-1:0]   req_op;
  logic [1:0]          req_alusrc;
  logic [DATA_W-1:0]   alu_a, alu_b, alu_imm;
  logic [OP_W-1:0]     alu_op;
  logic                alu_alusrc;
  logic [DATA_W-1:0]   alu_result;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_result;
  logic                rsp_zero;
  logic                busy;
  logic [CNT_W-1:0]    op_count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic              port;
    logic [DATA_W-1:0] res;
    logic              zero;
  } exp_t;

  exp_t sbq[$];
  exp_t pend[2];

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_imm(req_imm),
    .req_op(req_op), .req_alusrc(req_alusrc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm),
    .alu_op(alu_op), .alu_alusrc(alu_alusrc), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .busy(busy), .op_count(op_count)
  );

  // Stand-in for the external combinational ALU.
  logic [DATA_W-1:0] opb;
  always_comb begin
    opb = alu_alusrc ? alu_imm : alu_b;
    case (alu_op)
      4'h0:    alu_result = alu_a + opb;
      4'h1:    alu_result = alu_a - opb;
      4'h6:    alu_result = alu_a << opb[5:0];
      default: alu_result = alu_a ^ opb;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: push on accept, pop and compare on response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (req_ready[i]) sbq.push_back(pend[i]);
      end
      if (rsp_valid != 2'b00) check("rsp_valid_onehot", {63'd0, rsp_valid == 2'b11}, 64'd0);
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_rsp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("sb_rsp_port", rsp_valid, e.port ? 64'd2 : 64'd1);
          check("sb_rsp_result", rsp_result, e.res);
          check("sb_rsp_zero", rsp_zero, e.zero);
        end
      end
    end
  end

  task automatic set_req(input int p, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] imm, input logic [3:0] op, input logic src,
                         input logic [63:0] exp_res);
    req_a[p*DATA_W +: DATA_W]   = a;
    req_b[p*DATA_W +: DATA_W]   = b;
    req_imm[p*DATA_W +: DATA_W] = imm;
    req_op[p*OP_W +: OP_W]      = op;
    req_alusrc[p]               = src;
    pend[p]                     = '{port: p[0], res: exp_res, zero: (exp_res == 64'd0)};
    req_valid[p]                = 1'b1;
  endtask

  task automatic wait_accept(input int p);
    bit ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[p]) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!busy && rsp_valid == 2'b00) begin ok = 1; break; end
    end
    if (!ok) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_op(input int p, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] imm, input logic [3:0] op, input logic src,
                        input logic [63:0] exp_res);
    @(posedge clk); #1;
    set_req(p, a, b, imm, op, src, exp_res);
    wait_accept(p);
    @(negedge clk);
    check("exec_alusrc", alu_alusrc, src);
    check("exec_op", alu_op, op);
    wait_idle();
  endtask

  initial begin
    logic [1:0] grants[$];
    logic [CNT_W-1:0] base;

    rst        = 1'b1;
    req_valid  = 2'b00;
    req_a      = '0;
    req_b      = '0;
    req_imm    = '0;
    req_op     = '0;
    req_alusrc = 2'b00;
    rsp_ready  = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_rsp_result", rsp_result, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: add 5+3, latency check
    @(posedge clk); #1;
    set_req(0, 64'd5, 64'd3, 64'd0, 4'h0, 1'b0, 64'd8);
    @(negedge clk);
    check("t1_req_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check("t1_exec_rsp_valid", rsp_valid, 2'b00);
    check("t1_exec_busy", busy, 1);
    check("t1_exec_req_ready", req_ready, 2'b00);
    check("t1_exec_alu_a", alu_a, 64'd5);
    @(negedge clk);
    check("t1_rsp_valid", rsp_valid, 2'b01);
    wait_idle();
    check("t1_op_count", op_count, 1);

    // T2: shift with immediate
    run_op(0, 64'd2, 64'd99, 64'd10, 4'h6, 1'b1, 64'd2048);
    // T3: subtract to zero on requester 1
    run_op(1, 64'd7, 64'd7, 64'd0, 4'h1, 1'b0, 64'd0);
    check("t3_op_count", op_count, 3);

    // T4: contention, alternating grants
    base = op_count;
    @(posedge clk); #1;
    set_req(0, 64'd1, 64'd1, 64'd0, 4'h0, 1'b0, 64'd2);
    set_req(1, 64'd10, 64'd4, 64'd0, 4'h1, 1'b0, 64'd6);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) grants.push_back(req_ready);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check("t4_grant_count", grants.size(), 4);
    for (int g = 0; g < 4 && g < grants.size(); g++)
      check("t4_grant_order", grants[g], (g % 2 == 0) ? 2'b01 : 2'b10);
    check("t4_op_count", op_count, base + 4);
    wait_idle();

    // T5: requester 1 stalls its response while req0 waits
    rsp_ready = 2'b01;
    @(posedge clk); #1;
    set_req(1, 64'd3, 64'd4, 64'd0, 4'h0, 1'b0, 64'd7);
    wait_accept(1);
    set_req(0, 64'd100, 64'd1, 64'd0, 4'h1, 1'b0, 64'd99);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t5_hold_valid", rsp_valid, 2'b10);
      check("t5_hold_result", rsp_result, 64'd7);
      check("t5_hold_req_ready", req_ready, 2'b00);
      check("t5_hold_busy", busy, 1);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    @(negedge clk);
    check("t5_handshake_req_ready", req_ready, 2'b00);
    @(negedge clk);
    check("t5_req0_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();

    // T6: reset during EXEC drops the op
    @(posedge clk); #1;
    set_req(0, 64'd9, 64'd9, 64'd0, 4'h0, 1'b0, 64'd18);
    wait_accept(0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_exec_busy", busy, 1);
    @(negedge clk);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_rsp_valid", rsp_valid, 2'b00);
    check("t6_rst_op_count", op_count, 0);
    check("t6_rst_alu_a", alu_a, 0);
    check("t6_rst_alu_b", alu_b, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    repeat (3) @(negedge clk);
    check("t6_no_rsp_after_rst", rsp_valid, 2'b00);
    @(posedge clk); #1;
    set_req(0, 64'd20, 64'd22, 64'd0, 4'h0, 1'b0, 64'd42);
    set_req(1, 64'd1, 64'd1, 64'd0, 4'h0, 1'b0, 64'd2);
    @(negedge clk);
    check("t6_first_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();
    check("t6_op_count", op_count, 1);

    check("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule
